// File: rtl/pwm_deadtime.sv
// Complementary dead-time inserter for one PWM channel.
// Turns PWM_IN into high/low gate drives that are never active together,
// with a programmable dead interval on each edge and a latched fault stop.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_OFF    | channel disabled or just released from fault, both off
// S_LOW    | low-side drive active
// S_DT_LH  | dead interval before the high side turns on
// S_HIGH   | high-side drive active
// S_DT_HL  | dead interval before the low side turns on
// S_FAULT  | latched fault, both off until FAULT_CLR with FAULT low
module pwm_deadtime #(
  parameter int P_DT_BITWIDTH = 8
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     PWM_IN,
  input  logic                     EN,
  input  logic [P_DT_BITWIDTH-1:0] DT_RISE,
  input  logic [P_DT_BITWIDTH-1:0] DT_FALL,
  input  logic                     POL_H,
  input  logic                     POL_L,
  input  logic                     FAULT,
  input  logic                     FAULT_CLR,
  output logic                     PWM_H,
  output logic                     PWM_L,
  output logic                     FAULT_ACT,
  output logic                     DT_BUSY
);

  typedef enum logic [2:0] {
    S_OFF   = 3'd0,
    S_LOW   = 3'd1,
    S_DT_LH = 3'd2,
    S_HIGH  = 3'd3,
    S_DT_HL = 3'd4,
    S_FAULT = 3'd5
  } state_t;

  localparam logic [P_DT_BITWIDTH-1:0] CNT_ZERO = '0;
  localparam logic [P_DT_BITWIDTH-1:0] CNT_ONE  = {{(P_DT_BITWIDTH-1){1'b0}}, 1'b1};

  state_t                     state_q, state_d;
  logic [P_DT_BITWIDTH-1:0]   cnt_q, cnt_d;
  logic                       h_act, l_act;

  // State and dead-time counter registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_OFF;
      cnt_q   <= CNT_ZERO;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic: fault beats disable, disable beats normal switching.
  // A zero dead time skips the dead state so the counter never sees a 0 load.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (FAULT) begin
      state_d = S_FAULT;
      cnt_d   = CNT_ZERO;
    end else if (!EN && state_q != S_FAULT) begin
      state_d = S_OFF;
      cnt_d   = CNT_ZERO;
    end else begin
      case (state_q)
        S_OFF, S_LOW: begin
          if (PWM_IN) begin
            if (DT_RISE == CNT_ZERO) begin
              state_d = S_HIGH;
              cnt_d   = CNT_ZERO;
            end else begin
              state_d = S_DT_LH;
              cnt_d   = DT_RISE;
            end
          end else begin
            state_d = S_LOW;
          end
        end
        S_DT_LH: begin
          if (!PWM_IN) begin
            state_d = S_LOW;
            cnt_d   = CNT_ZERO;
          end else if (cnt_q == CNT_ONE) begin
            state_d = S_HIGH;
            cnt_d   = CNT_ZERO;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
        S_HIGH: begin
          if (!PWM_IN) begin
            if (DT_FALL == CNT_ZERO) begin
              state_d = S_LOW;
              cnt_d   = CNT_ZERO;
            end else begin
              state_d = S_DT_HL;
              cnt_d   = DT_FALL;
            end
          end
        end
        S_DT_HL: begin
          if (PWM_IN) begin
            state_d = S_HIGH;
            cnt_d   = CNT_ZERO;
          end else if (cnt_q == CNT_ONE) begin
            state_d = S_LOW;
            cnt_d   = CNT_ZERO;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
        S_FAULT: begin
          if (FAULT_CLR) begin
            state_d = S_OFF;
            cnt_d   = CNT_ZERO;
          end
        end
        default: begin
          state_d = S_OFF;
          cnt_d   = CNT_ZERO;
        end
      endcase
    end
  end

  // Moore output decode; polarity applied after the state decode.
  always_comb begin
    h_act     = (state_q == S_HIGH);
    l_act     = (state_q == S_LOW);
    PWM_H     = h_act ^ POL_H;
    PWM_L     = l_act ^ POL_L;
    FAULT_ACT = (state_q == S_FAULT);
    DT_BUSY   = (state_q == S_DT_LH) || (state_q == S_DT_HL);
  end

  // Shoot-through guard: both drives active at once is a design error.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      assert (!(h_act && l_act));
    end
  end

endmodule
